arb_rr_mux: RTL and testbench
=============================

Name: arb_rr_mux

Overview:
- Round-robin arbiter that shares one output stream among WIDTH valid/ready requesters.
- Grant is one-hot. The same grant vector drives a mux_oht_tree that selects the winning requester's data.
- Selected data lands in a single registered output stage with valid/ready backpressure.
- Sits in front of any shared resource (bus port, memory port, shared pipeline) that accepts one transfer per cycle.

Parameters:
- DAT_T, logic [8-1:0], payload type carried per requester.
- WIDTH, 4, number of requesters. Must be a power of SPLIT.
- SPLIT, 2, tree radix forwarded to mux_oht_tree.
- IMPLEMENTATION, 0, mux implementation option forwarded to mux_oht_tree.
- WIDTH_LOG, $clog2(WIDTH), localparam, width of out_idx (minimum 1).

Ports:
- clk, input, 1, single clock. All state updates on the rising edge.
- rst, input, 1, synchronous active-high reset.
- req_vld, input, WIDTH, per-requester valid.
- req_rdy, output, WIDTH, per-requester ready. At most one bit set.
- req_dat, input, DAT_T [WIDTH-1:0], per-requester payload array.
- out_vld, output, 1, output register holds a transfer.
- out_rdy, input, 1, downstream accepts.
- out_dat, output, DAT_T, registered selected payload.
- out_idx, output, WIDTH_LOG, binary index of the requester that produced out_dat.

Behaviour:
- Interface: one clock (clk). Reset rst is synchronous, active-high, and sampled only on the clk rising edge.
- Reset values:
  - out_vld=0, out_dat='0, out_idx=0.
  - Priority pointer ptr (one-hot, WIDTH bits) = bit 0 set.
  - req_rdy is combinational and therefore 0 while out_vld=0 and req_vld=0.
- Slot free: load = !out_vld || out_rdy. This is combinational, so there is a direct path out_rdy -> req_rdy. That path is intended and documented.
- Grant: gnt is the one-hot vector of the first set bit of req_vld, searching circularly from the ptr position upward with wrap past WIDTH-1 to 0.
  - gnt = 0 when req_vld = 0.
  - Purely combinational; no locking.
- Handshake: req_rdy = gnt & {WIDTH{load}}. A requester transfers when req_vld[i] && req_rdy[i].
- Requesters follow the valid/ready rule: hold vld and dat stable until accepted. The arbiter does not rely on this; the decision is re-evaluated every cycle.
- On any cycle with load && |req_vld:
  - out_vld <= 1.
  - out_dat <= mux_oht_tree(gnt, req_dat).
  - out_idx <= binary(gnt).
  - ptr <= gnt rotated left by 1, so grant WIDTH-1 wraps ptr to bit 0.
- On load && !|req_vld: out_vld <= 0. out_dat, out_idx and ptr hold.
- On !load (out_vld=1, out_rdy=0): all registers hold and req_rdy = 0.
- Throughput and latency:
  - One transfer per cycle when out_rdy stays 1.
  - Latency is 1 cycle from accepted request to out_vld.
- Fairness: with all requesters continuously valid, each requester is granted exactly once in every WIDTH consecutive transfers.
- Reset mid-operation: any pending out_vld transfer is discarded, ptr returns to bit 0, and no req_rdy is asserted in the reset cycle.
- WIDTH=1: grant equals req_vld[0], ptr is constant, and out_idx is a constant 0.
- The vld output of mux_oht_tree is unused; it is equivalent to |gnt and may be used as an internal consistency check in assertions.
- Assertions (simulation only):
  - $onehot0(req_rdy).
  - $onehot(ptr).
  - out_dat and out_idx stable while out_vld && !out_rdy.

Decomposition:
- Shared package arb_pkg holds:
  - Function oht2bin (one-hot to binary, parametrized width).
  - Function rotl1 (rotate one-hot left by 1).
- No new typedefs; DAT_T is still passed by parameter.
- Natural sub-module: arb_rr_oht, a combinational round-robin grant generator.
  - Inputs: req, ptr.
  - Output: one-hot gnt.
  - Implemented as a double-width priority mask.
- arb_rr_mux instantiates arb_rr_oht and the existing mux_oht_tree, and owns all registers.

Test Plan (WIDTH=4, DAT_T 8-bit, req_dat[i]=8'h10+i):
1. Assert rst for 2 cycles with random req_vld -> during and after reset: out_vld=0, out_dat=0, out_idx=0, ptr=4'b0001; req_rdy=0 in reset cycles.
2. req_vld=4'b1111 held, out_rdy=1 -> out_idx sequence 0,1,2,3,0,1 on consecutive cycles; out_dat 10,11,12,13,10,11; exactly one req_rdy bit per cycle.
3. After out_vld=1 with idx=1, drop out_rdy for 3 cycles -> req_rdy=0000 and out_dat=8'h11, out_idx=1 stable. Raise out_rdy -> next out_idx=2 in the following cycle.
4. ptr=4'b1000 (after granting 2), req_vld=4'b0101 -> grant order 0 (wrap), then 2; out_idx 0 then 2.
5. Only req_vld[1]=1 continuously, out_rdy=1 -> out_idx=1 every cycle, out_vld stays 1. Then req_vld=0 -> out_vld=0 on the next cycle.
6. Assert rst while out_vld=1, out_rdy=0, req_vld=4'b1111 -> next cycle out_vld=0, ptr=0001. First grant after reset release is idx 0.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared helpers for the round-robin arbiter: one-hot encoding utilities.
// Vectors are handled as 32-bit containers, so arbiters up to 32 requesters are supported.
package arb_pkg;

    localparam int unsigned VEC_W = 32;

    // Binary index of the set bit in a one-hot vector (0 when empty).
    function automatic int unsigned oht2bin(input logic [VEC_W-1:0] oht);
        int unsigned bin;
        bin = 0;
        for (int unsigned i = 0; i < VEC_W; i++) begin
            if (oht[5'(i)]) bin = bin | i;
        end
        return bin;
    endfunction

    // Rotate the low w bits of a one-hot vector left by one, wrapping bit w-1 to bit 0.
    function automatic logic [VEC_W-1:0] rotl1(input logic [VEC_W-1:0] vec, input int unsigned w);
        logic [VEC_W-1:0] rot;
        rot = '0;
        for (int unsigned i = 0; i < VEC_W; i++) begin
            if (i < w) rot[5'((i + 1) % w)] = vec[5'(i)];
        end
        return rot;
    endfunction

endpackage

// File: rtl/arb_rr_oht.sv
// Combinational round-robin grant: first set request at or above ptr, wrapping around.
// Uses a double-width copy of req so the wrap-around search is a single lowest-bit isolate.
module arb_rr_oht #(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] req,
    input  logic [WIDTH-1:0] ptr,
    output logic [WIDTH-1:0] gnt
);

    localparam int unsigned W2 = 2 * WIDTH;

    logic [W2-1:0] mask;
    logic [W2-1:0] dbl;
    logic [W2-1:0] lowest;

    // Lower copy keeps bits at/above ptr, upper copy keeps everything (the wrapped part).
    assign mask   = ~(W2'(ptr) - W2'(1));
    assign dbl    = {req, req} & mask;
    assign lowest = dbl & (~dbl + W2'(1));
    assign gnt    = lowest[WIDTH-1:0] | lowest[W2-1:WIDTH];

endmodule

// File: rtl/mux_oht_tree.sv
// One-hot select multiplexer built as a SPLIT-ary reduction tree.
// IMPLEMENTATION 0: AND-OR reduction; otherwise: first-valid-child selection per node.
module mux_oht_tree #(
    parameter type         DAT_T          = logic [7:0],
    parameter int unsigned WIDTH          = 4,
    parameter int unsigned SPLIT          = 2,
    parameter int unsigned IMPLEMENTATION = 0
) (
    input  logic [WIDTH-1:0] oht,
    input  DAT_T [WIDTH-1:0] din,
    output DAT_T             dout,
    output logic             vld
);

    // Number of tree levels above the leaves.
    function automatic int unsigned levels();
        int unsigned n;
        int unsigned l;
        n = WIDTH;
        l = 0;
        while (n > 1 && SPLIT > 1) begin
            n = n / SPLIT;
            l++;
        end
        return l;
    endfunction

    // Number of nodes on a given level (level 0 = leaves).
    function automatic int unsigned lvl_cnt(input int unsigned lvl);
        int unsigned n;
        n = WIDTH;
        for (int unsigned k = 0; k < lvl; k++) n = n / SPLIT;
        return n;
    endfunction

    // Flat-array offset of the first node of a level.
    function automatic int unsigned lvl_off(input int unsigned lvl);
        int unsigned off;
        off = 0;
        for (int unsigned k = 0; k < lvl; k++) off = off + lvl_cnt(k);
        return off;
    endfunction

    localparam int unsigned LEVELS = levels();
    localparam int unsigned TOTAL  = lvl_off(LEVELS) + 1;

    DAT_T node_dat [TOTAL];
    logic node_vld [TOTAL];

    // Leaves: payloads masked by their select bit.
    for (genvar i = 0; i < WIDTH; i++) begin : g_leaf
        assign node_dat[i] = oht[i] ? din[i] : '0;
        assign node_vld[i] = oht[i];
    end

    for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
        for (genvar n = 0; n < lvl_cnt(l + 1); n++) begin : g_node
            localparam int unsigned CI = lvl_off(l) + n * SPLIT;
            localparam int unsigned PO = lvl_off(l + 1) + n;
            DAT_T node_d;
            logic node_v;

            // Combine SPLIT children into one parent node.
            always_comb begin
                node_d = '0;
                node_v = 1'b0;
                for (int unsigned s = 0; s < SPLIT; s++) begin
                    if (IMPLEMENTATION == 0) begin
                        node_d = node_d | node_dat[CI + s];
                    end else if (!node_v && node_vld[CI + s]) begin
                        node_d = node_dat[CI + s];
                    end
                    node_v = node_v | node_vld[CI + s];
                end
            end

            assign node_dat[PO] = node_d;
            assign node_vld[PO] = node_v;
        end
    end

    assign dout = node_dat[TOTAL-1];
    assign vld  = node_vld[TOTAL-1];

endmodule

// File: rtl/arb_rr_mux.sv
// Round-robin arbiter sharing one registered valid/ready output among WIDTH requesters.
// req_rdy depends combinationally on out_rdy (slot-free path) by design.
module arb_rr_mux
    import arb_pkg::*;
#(
    parameter type         DAT_T          = logic [7:0],
    parameter int unsigned WIDTH          = 4,
    parameter int unsigned SPLIT          = 2,
    parameter int unsigned IMPLEMENTATION = 0,
    localparam int unsigned WIDTH_LOG     = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     req_vld,
    output logic [WIDTH-1:0]     req_rdy,
    input  DAT_T [WIDTH-1:0]     req_dat,
    output logic                 out_vld,
    input  logic                 out_rdy,
    output DAT_T                 out_dat,
    output logic [WIDTH_LOG-1:0] out_idx
);

    logic [WIDTH-1:0] ptr;
    logic [WIDTH-1:0] gnt;
    logic             load;
    DAT_T             mux_dat;
    logic             mux_vld;

    arb_rr_oht #(
        .WIDTH (WIDTH)
    ) u_grant (
        .req (req_vld),
        .ptr (ptr),
        .gnt (gnt)
    );

    mux_oht_tree #(
        .DAT_T          (DAT_T),
        .WIDTH          (WIDTH),
        .SPLIT          (SPLIT),
        .IMPLEMENTATION (IMPLEMENTATION)
    ) u_mux (
        .oht  (gnt),
        .din  (req_dat),
        .dout (mux_dat),
        .vld  (mux_vld)
    );

    // Output slot can take a new transfer when empty or being drained this cycle.
    assign load    = !out_vld || out_rdy;
    assign req_rdy = (rst || !load) ? '0 : gnt;

    // Output stage and priority pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_vld <= 1'b0;
            out_dat <= '0;
            out_idx <= '0;
            ptr     <= WIDTH'(1);
        end else if (load) begin
            if (|req_vld) begin
                out_vld <= 1'b1;
                out_dat <= mux_dat;
                out_idx <= WIDTH_LOG'(oht2bin(VEC_W'(gnt)));
                ptr     <= WIDTH'(rotl1(VEC_W'(gnt), WIDTH));
            end else begin
                out_vld <= 1'b0;
            end
        end
    end

    // Simulation-only consistency checks.
    always @(posedge clk) begin
        if (!rst) begin
            assert ($onehot0(req_rdy));
            assert ($onehot(ptr));
            assert (mux_vld == (|gnt));
            if (!$past(rst) && $past(out_vld) && !$past(out_rdy)) begin
                assert (out_dat == $past(out_dat) && out_idx == $past(out_idx));
            end
        end
    end

endmodule

// File: tb/tb_arb_rr_mux.sv
// Testbench for arb_rr_mux: directed plan steps followed by randomized traffic,
// all checked against a behavioural round-robin model.
module tb_arb_rr_mux;

    localparam int unsigned W = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [W-1:0]      req_vld;
    logic [W-1:0]      req_rdy;
    logic [W-1:0][7:0] req_dat;
    logic              out_vld;
    logic              out_rdy;
    logic [7:0]        out_dat;
    logic [1:0]        out_idx;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state: output register contents and next-priority index.
    bit         m_vld = 1'b0;
    logic [7:0] m_dat = 8'h00;
    int         m_idx = 0;
    int         m_ptr = 0;

    arb_rr_mux #(
        .DAT_T          (logic [7:0]),
        .WIDTH          (W),
        .SPLIT          (2),
        .IMPLEMENTATION (0)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req_vld (req_vld),
        .req_rdy (req_rdy),
        .req_dat (req_dat),
        .out_vld (out_vld),
        .out_rdy (out_rdy),
        .out_dat (out_dat),
        .out_idx (out_idx)
    );

    always #5 clk = ~clk;

    // Winner: first valid requester starting at index p, going upward with wrap; -1 if none.
    function automatic int pick(input logic [W-1:0] v, input int p);
        for (int k = 0; k < int'(W); k++) begin
            int i;
            i = (p + k) % int'(W);
            if (v[i]) return i;
        end
        return -1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: inputs already driven after a falling edge.
    task automatic cycle();
        int         g;
        bit         load;
        logic [3:0] exp_rdy;
        #1;
        load    = !m_vld || out_rdy;
        g       = pick(req_vld, m_ptr);
        exp_rdy = (rst || !load || g < 0) ? 4'b0000 : 4'(1 << g);
        check("req_rdy", 32'(req_rdy), 32'(exp_rdy));
        @(posedge clk);
        if (rst) begin
            m_vld = 1'b0;
            m_dat = 8'h00;
            m_idx = 0;
            m_ptr = 0;
        end else if (load) begin
            if (g >= 0) begin
                m_vld = 1'b1;
                m_dat = req_dat[g];
                m_idx = g;
                m_ptr = (g + 1) % int'(W);
            end else begin
                m_vld = 1'b0;
            end
        end
        #1;
        check("out_vld", 32'(out_vld), 32'(m_vld));
        check("out_dat", 32'(out_dat), 32'(m_dat));
        check("out_idx", 32'(out_idx), 32'(m_idx));
        check("ptr", 32'(dut.ptr), 32'(1 << m_ptr));
        @(negedge clk);
    endtask

    initial begin
        rst     = 1'b1;
        out_rdy = 1'b1;
        req_vld = 4'($urandom);
        for (int i = 0; i < int'(W); i++) req_dat[i] = 8'(8'h10 + i);
        @(negedge clk);

        // Reset with random requests: nothing granted, registers cleared.
        for (int c = 0; c < 2; c++) begin
            req_vld = 4'($urandom);
            cycle();
        end
        check("rst_out_vld", 32'(out_vld), 32'd0);
        check("rst_ptr", 32'(dut.ptr), 32'h1);

        // All requesters valid: strict rotation 0,1,2,3,0,1.
        rst     = 1'b0;
        req_vld = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            cycle();
            check("rot_idx", 32'(out_idx), 32'(k % 4));
            check("rot_dat", 32'(out_dat), 32'(8'h10 + (k % 4)));
        end

        // Backpressure: everything holds, no ready.
        out_rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cycle();
            check("hold_idx", 32'(out_idx), 32'd1);
            check("hold_dat", 32'(out_dat), 32'h11);
        end
        out_rdy = 1'b1;
        cycle();
        check("resume_idx", 32'(out_idx), 32'd2);

        // ptr at 3: requests 0 and 2 -> wrap to 0 first, then 2.
        req_vld = 4'b0101;
        cycle();
        check("wrap_idx0", 32'(out_idx), 32'd0);
        cycle();
        check("wrap_idx2", 32'(out_idx), 32'd2);

        // Single requester streams every cycle, then output drains.
        req_vld = 4'b0010;
        for (int k = 0; k < 4; k++) begin
            cycle();
            check("single_idx", 32'(out_idx), 32'd1);
            check("single_vld", 32'(out_vld), 32'd1);
        end
        req_vld = 4'b0000;
        cycle();
        check("drain_vld", 32'(out_vld), 32'd0);

        // Reset while a transfer is stalled.
        req_vld = 4'b1111;
        cycle();
        out_rdy = 1'b0;
        rst     = 1'b1;
        cycle();
        check("midrst_vld", 32'(out_vld), 32'd0);
        check("midrst_ptr", 32'(dut.ptr), 32'h1);
        rst     = 1'b0;
        out_rdy = 1'b1;
        cycle();
        check("post_rst_idx", 32'(out_idx), 32'd0);

        // Randomized traffic with occasional reset.
        for (int c = 0; c < 400; c++) begin
            rst     = ($urandom_range(0, 49) == 0);
            req_vld = ($urandom_range(0, 3) == 0) ? 4'b1111 : 4'($urandom);
            out_rdy = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < int'(W); i++) req_dat[i] = 8'($urandom);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
